// File: rtl/prog_clk_div_if.sv
// ----------------------------------------------------------------------------
// prog_clk_div_if
// Control/status bundle of the programmable clock divider.
//   en_i       : run request
//   div_i      : requested divisor N
//   div_load_i : one-cycle strobe capturing div_i
//   clk_o      : divided clock, 50% duty for any N >= 2
//   tick_o     : one-cycle pulse at the start of each clk_o period
//   pend_o     : a captured divisor is waiting for a period boundary
//   cfg_err_o  : one-cycle pulse when a load is rejected (div_i < 2)
// Modports: master drives the requests, slave (the divider) answers them.
// ----------------------------------------------------------------------------
interface prog_clk_div_if #(
    parameter int unsigned DIV_WIDTH = 8
);
    logic                 en_i;
    logic [DIV_WIDTH-1:0] div_i;
    logic                 div_load_i;
    logic                 clk_o;
    logic                 tick_o;
    logic                 pend_o;
    logic                 cfg_err_o;

    modport master (
        output en_i, div_i, div_load_i,
        input  clk_o, tick_o, pend_o, cfg_err_o
    );

    modport slave (
        input  en_i, div_i, div_load_i,
        output clk_o, tick_o, pend_o, cfg_err_o
    );
endinterface

// File: rtl/prog_clk_div.sv
// ----------------------------------------------------------------------------
// prog_clk_div
// Programmable clock divider with 50% duty cycle for odd and even divisors.
// A new divisor is held pending and only takes effect at a period boundary,
// so a running period is never truncated or stretched.
// Ports:
//   clk_i : source clock (rising edge, plus one falling-edge phase register)
//   rst_n : asynchronous active-low reset
//   bus   : prog_clk_div_if.slave (en_i, div_i, div_load_i in;
//           clk_o, tick_o, pend_o, cfg_err_o out)
// ----------------------------------------------------------------------------
module prog_clk_div #(
    parameter int unsigned DIV_WIDTH   = 8,
    parameter int unsigned DIV_DEFAULT = 7
) (
    input  logic          clk_i,
    input  logic          rst_n,
    prog_clk_div_if.slave bus
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [DIV_WIDTH-1:0] LP_DIV_DEF = DIV_WIDTH'(DIV_DEFAULT);

    state_t               r_state, w_state_nxt;
    logic [DIV_WIDTH-1:0] r_cnt,   w_cnt_nxt;
    logic [DIV_WIDTH-1:0] r_na,    w_na_nxt;
    logic [DIV_WIDTH-1:0] r_np,    w_np_nxt;
    logic                 r_qp,    w_qp_nxt;
    logic                 r_tick,  w_tick_nxt;
    logic                 r_pend,  w_pend_nxt;
    logic                 r_err,   w_err_nxt;
    logic                 r_qn;

    logic [DIV_WIDTH-1:0] w_half;
    logic [DIV_WIDTH-1:0] w_last;
    logic [DIV_WIDTH-1:0] w_cnt_inc;
    logic                 w_load_ok;
    logic                 w_boundary;

    assign w_half     = r_na >> 1;
    assign w_last     = r_na - DIV_WIDTH'(1);
    assign w_cnt_inc  = r_cnt + DIV_WIDTH'(1);
    assign w_load_ok  = bus.div_load_i && (bus.div_i >= DIV_WIDTH'(2));
    assign w_boundary = (r_state == RUN) && (r_cnt == w_last);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_na_nxt    = r_na;
        w_np_nxt    = r_np;
        w_pend_nxt  = r_pend;
        w_qp_nxt    = r_qp;
        w_tick_nxt  = 1'b0;
        w_err_nxt   = bus.div_load_i && !w_load_ok;

        if (w_load_ok) begin
            w_np_nxt   = bus.div_i;
            w_pend_nxt = 1'b1;
        end

        unique case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                w_qp_nxt  = 1'b0;
                // A pending divisor is applied now; a load in this same cycle
                // becomes the next pending value.
                if (r_pend) begin
                    w_na_nxt   = r_np;
                    w_pend_nxt = w_load_ok;
                end
                if (bus.en_i) begin
                    w_state_nxt = RUN;
                    w_qp_nxt    = 1'b1;
                    w_tick_nxt  = 1'b1;
                end
            end
            RUN: begin
                if (w_boundary) begin
                    // A load on the boundary itself bypasses the pending slot.
                    if (w_load_ok) begin
                        w_na_nxt   = bus.div_i;
                        w_pend_nxt = 1'b0;
                    end else if (r_pend) begin
                        w_na_nxt   = r_np;
                        w_pend_nxt = 1'b0;
                    end
                    w_cnt_nxt = '0;
                    if (bus.en_i) begin
                        w_qp_nxt   = 1'b1;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_qp_nxt    = 1'b0;
                    end
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    w_qp_nxt  = (w_cnt_inc < w_half);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_na    <= LP_DIV_DEF;
            r_np    <= LP_DIV_DEF;
            r_qp    <= 1'b0;
            r_tick  <= 1'b0;
            r_pend  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_na    <= w_na_nxt;
            r_np    <= w_np_nxt;
            r_qp    <= w_qp_nxt;
            r_tick  <= w_tick_nxt;
            r_pend  <= w_pend_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Half-cycle delayed copy of the phase; ORed in for odd divisors to add
    // the extra half clk_i of high time.
    always_ff @(negedge clk_i or negedge rst_n) begin
        if (!rst_n) r_qn <= 1'b0;
        else        r_qn <= r_qp;
    end

    // r_na[0] only changes at a boundary, where r_qp rises and r_qn is low,
    // so the mode select cannot glitch.
    assign bus.clk_o     = r_na[0] ? (r_qp | r_qn) : r_qp;
    assign bus.tick_o    = r_tick;
    assign bus.pend_o    = r_pend;
    assign bus.cfg_err_o = r_err;

endmodule

// File: doc/prog_clk_div.md
PROG_CLK_DIV -- requirements
Module: prog_clk_div

Interface
REQ-001 SHALL have parameter DIV_WIDTH, default 8, width of divisor and internal counter.
REQ-002 SHALL have parameter DIV_DEFAULT, default 7, divisor applied out of reset; legal range 2..2^DIV_WIDTH-1.
REQ-003 SHALL have port clk_i  input  1  source clock; all logic on rising edge except the odd-mode half-cycle register (falling edge).
REQ-004 SHALL have port rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port en_i  input  1  run request, sampled on clk_i rising edge.
REQ-006 SHALL have port div_i  input  DIV_WIDTH  requested divisor N.
REQ-007 SHALL have port div_load_i  input  1  one-cycle strobe capturing div_i.
REQ-008 SHALL have port clk_o  output  1  divided clock, 50% duty for any N>=2, odd or even.
REQ-009 SHALL have port tick_o  output  1  one clk_i cycle pulse marking each clk_o period start.
REQ-010 SHALL have port pend_o  output  1  high while a captured divisor waits for a period boundary.
REQ-011 SHALL have port cfg_err_o  output  1  one-cycle pulse when a load is rejected.

Function
REQ-012 SHALL hold applied divisor N_a, pending divisor N_p, counter cnt (DIV_WIDTH bits), state IDLE/RUN, posedge phase q_p, negedge phase q_n.
REQ-013 SHALL define H = floor(N_a/2), odd = N_a[0].
REQ-014 IDLE: cnt=0, q_p=0; on rising edge with en_i=1 SHALL go RUN, cnt<=0, q_p<=1, tick_o<=1.
REQ-015 RUN, cnt<N_a-1: SHALL set cnt<=cnt+1, q_p<=(cnt+1<H).
REQ-016 RUN, cnt==N_a-1 (boundary): if en_i=1 SHALL set cnt<=0, q_p<=1, tick_o<=1; else SHALL go IDLE with q_p<=0.
REQ-017 SHALL never truncate a period: en_i deassertion takes effect only at boundary.
REQ-018 q_n SHALL load q_p on every falling edge of clk_i.
REQ-019 clk_o SHALL equal q_p|q_n when odd=1, q_p when odd=0; high time N_a/2 clk_i periods, total period N_a.
REQ-020 div_load_i with div_i>=2 SHALL capture N_p<=div_i and set pend_o next cycle.
REQ-021 div_load_i with div_i<2 SHALL be ignored (N_p, pend_o unchanged) and pulse cfg_err_o next cycle.
REQ-022 Multiple valid loads before a boundary: last one SHALL win.
REQ-023 At a boundary (RUN) or any cycle in IDLE with pend_o=1: SHALL set N_a<=N_p, clear pend_o; new N_a governs the period starting there.
REQ-024 Load coinciding with boundary SHALL be applied at that same boundary (div_i bypasses N_p).
REQ-025 odd SHALL change only when N_a changes, so clk_o never glitches at mode switch.
REQ-026 tick_o, pend_o, cfg_err_o SHALL be registered; clk_o SHALL be combinational only as the OR/select of q_p, q_n.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, cnt=0, q_p=0, q_n=0, clk_o=0, tick_o=0, pend_o=0, cfg_err_o=0, N_a=N_p=DIV_DEFAULT.
REQ-028 Reset mid-period SHALL abort the period with no further clk_o edge until restart per REQ-014.

Verification
REQ-029 Defaults, en_i=1 after reset: clk_o period 7 clk_i, high 3.5 cycles, tick_o every 7 cycles, first rise 1 edge after en_i sampled.
REQ-030 Load div_i=4 mid-period of N=7: pend_o=1 until boundary; current period stays 7; next periods 4, high exactly 2, q_n unused.
REQ-031 Load div_i=1 then div_i=0: cfg_err_o pulses twice, N_a unchanged, pend_o stays 0.
REQ-032 Loads 5 then 9 in same period: next period length 9, high 4.5 cycles.
REQ-033 en_i dropped at cnt=2 of N=6: period completes (6 cycles), clk_o then stays 0; reassert gives rise 1 edge later.
REQ-034 rst_n asserted while clk_o high (N=3): clk_o drops asynchronously; after release N_a=7, clk_o low until en_i sampled.
